// File: rtl/axi_16bit_splitter_pkg.sv
// rtl/axi_16bit_splitter_pkg.sv - shared widths and lane state type for the 16-to-8 splitter
package axi_16bit_splitter_pkg;
  localparam int BYTE_W      = 8;
  localparam int WORD_W      = 16;
  localparam int COUNT_W_DEF = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;
endpackage

// File: rtl/axi_16bit_splitter_if.sv
// rtl/axi_16bit_splitter_if.sv - 16-bit input stream plus two 8-bit output lanes
interface axi_16bit_splitter_if;
  import axi_16bit_splitter_pkg::*;

  logic [WORD_W-1:0] s_axis_data;
  logic              s_axis_valid;
  logic              s_axis_ready;
  logic [BYTE_W-1:0] m_axis_data1;
  logic              m_axis_valid1;
  logic              m_axis_ready1;
  logic [BYTE_W-1:0] m_axis_data2;
  logic              m_axis_valid2;
  logic              m_axis_ready2;

  // slave: the splitter's view; master: producer and both consumers
  modport slave (
    input  s_axis_data, s_axis_valid, m_axis_ready1, m_axis_ready2,
    output s_axis_ready, m_axis_data1, m_axis_valid1, m_axis_data2, m_axis_valid2
  );

  modport master (
    output s_axis_data, s_axis_valid, m_axis_ready1, m_axis_ready2,
    input  s_axis_ready, m_axis_data1, m_axis_valid1, m_axis_data2, m_axis_valid2
  );
endinterface

// File: rtl/axi_8bit_reg_slice.sv
// rtl/axi_8bit_reg_slice.sv - single-lane byte holding register with load/drain handshake
module axi_8bit_reg_slice
  import axi_16bit_splitter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [BYTE_W-1:0] data,
  output logic              free
);
  lane_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // load is only issued while free, so load-and-drain keeps the lane FULL
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (ready && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

  assign valid = (state_q == FULL);
  assign free  = (state_q == EMPTY) || ready;
endmodule

// File: rtl/axi_16bit_splitter.sv
// rtl/axi_16bit_splitter.sv - splits each 16-bit stream word into two independent 8-bit lanes
module axi_16bit_splitter
  import axi_16bit_splitter_pkg::*;
#(
  parameter bit SWAP    = 1'b0,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               aresetn,
  axi_16bit_splitter_if.slave bus,
  output logic [COUNT_W-1:0] word_count
);
  logic              free1, free2;
  logic              accept;
  logic [BYTE_W-1:0] byte_lo, byte_hi;
  logic [BYTE_W-1:0] lane1_byte, lane2_byte;

  // a word goes in only when both lanes can take their byte on this edge
  assign bus.s_axis_ready = aresetn && free1 && free2;
  assign accept           = bus.s_axis_valid && bus.s_axis_ready;

  assign byte_lo    = bus.s_axis_data[BYTE_W-1:0];
  assign byte_hi    = bus.s_axis_data[WORD_W-1:BYTE_W];
  assign lane1_byte = SWAP ? byte_hi : byte_lo;
  assign lane2_byte = SWAP ? byte_lo : byte_hi;

  axi_8bit_reg_slice u_lane1 (
    .clk       (clk),
    .rst_n     (aresetn),
    .load      (accept),
    .load_data (lane1_byte),
    .ready     (bus.m_axis_ready1),
    .valid     (bus.m_axis_valid1),
    .data      (bus.m_axis_data1),
    .free      (free1)
  );

  axi_8bit_reg_slice u_lane2 (
    .clk       (clk),
    .rst_n     (aresetn),
    .load      (accept),
    .load_data (lane2_byte),
    .ready     (bus.m_axis_ready2),
    .valid     (bus.m_axis_valid2),
    .data      (bus.m_axis_data2),
    .free      (free2)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      word_count <= '0;
    end else if (accept) begin
      word_count <= word_count + COUNT_W'(1);
    end
  end
endmodule

// File: tb/tb_axi_16bit_splitter.sv
// tb/tb_axi_16bit_splitter.sv - directed vectors and scoreboard for the 16-to-8 splitter
module tb_axi_16bit_splitter;
  logic clk = 1'b0;
  logic rst0, rst2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_16bit_splitter_if if0 ();
  axi_16bit_splitter_if if1 ();
  axi_16bit_splitter_if if2 ();

  axi_16bit_splitter #(.SWAP(1'b0), .COUNT_W(16)) dut0 (.clk(clk), .aresetn(rst0), .bus(if0), .word_count(cnt0));
  axi_16bit_splitter #(.SWAP(1'b1), .COUNT_W(16)) dut1 (.clk(clk), .aresetn(rst0), .bus(if1), .word_count(cnt1));
  axi_16bit_splitter #(.SWAP(1'b0), .COUNT_W(4))  dut2 (.clk(clk), .aresetn(rst2), .bus(if2), .word_count(cnt2));

  typedef struct {
    logic [15:0] data;
    logic        valid;
    logic        r1;
    logic        r2;
    logic        e_rdy;
    logic        e_v1;
    logic [7:0]  e_d1;
    logic        e_v2;
    logic [7:0]  e_d2;
    int          e_cnt;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  initial begin
    int sent;
    logic pending;
    logic [15:0] cur;

    // single word, then skewed backpressure (lane2 held 5 cycles), on the SWAP=0 instance
    vecs[0]  = '{16'h12AB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 0};
    vecs[1]  = '{16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAB, 1'b1, 8'h12, 1};
    vecs[2]  = '{16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hAB, 1'b0, 8'h12, 1};
    vecs[3]  = '{16'h3456, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hAB, 1'b0, 8'h12, 1};
    vecs[4]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h56, 1'b1, 8'h34, 2};
    vecs[5]  = '{16'h7777, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h56, 1'b1, 8'h34, 2};
    vecs[6]  = '{16'h7777, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h56, 1'b1, 8'h34, 2};
    vecs[7]  = '{16'h7777, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h56, 1'b1, 8'h34, 2};
    vecs[8]  = '{16'h7777, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h56, 1'b1, 8'h34, 2};
    vecs[9]  = '{16'h7777, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h56, 1'b1, 8'h34, 2};
    vecs[10] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 8'h77, 3};
    vecs[11] = '{16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 8'h77, 3};
    vecs[12] = '{16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 8'h77, 3};

    rst0 = 1'b0;
    rst2 = 1'b0;
    if0.s_axis_data = 16'hBEEF; if0.s_axis_valid = 1'b1; if0.m_axis_ready1 = 1'b1; if0.m_axis_ready2 = 1'b1;
    if1.s_axis_data = 16'hBEEF; if1.s_axis_valid = 1'b1; if1.m_axis_ready1 = 1'b1; if1.m_axis_ready2 = 1'b1;
    if2.s_axis_data = 16'hBEEF; if2.s_axis_valid = 1'b1; if2.m_axis_ready1 = 1'b1; if2.m_axis_ready2 = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", int'(if0.s_axis_ready), 0);
    check("rst_valid1", int'(if0.m_axis_valid1), 0);
    check("rst_valid2", int'(if0.m_axis_valid2), 0);
    check("rst_data1", int'(if0.m_axis_data1), 0);
    check("rst_count", int'(cnt0), 0);
    check("rst_ready_dut2", int'(if2.s_axis_ready), 0);

    @(negedge clk);
    if0.s_axis_valid = 1'b0;
    if1.s_axis_valid = 1'b0;
    if2.s_axis_valid = 1'b0;
    rst0 = 1'b1;
    rst2 = 1'b1;
    @(negedge clk);
    #1;
    check("release_ready", int'(if0.s_axis_ready), 1);
    check("release_valid1", int'(if0.m_axis_valid1), 0);
    check("release_valid2", int'(if0.m_axis_valid2), 0);
    check("release_count", int'(cnt0), 0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if0.s_axis_data   = vecs[i].data;
      if0.s_axis_valid  = vecs[i].valid;
      if0.m_axis_ready1 = vecs[i].r1;
      if0.m_axis_ready2 = vecs[i].r2;
      #1;
      check($sformatf("vec%0d_ready", i), int'(if0.s_axis_ready), int'(vecs[i].e_rdy));
      check($sformatf("vec%0d_valid1", i), int'(if0.m_axis_valid1), int'(vecs[i].e_v1));
      check($sformatf("vec%0d_data1", i), int'(if0.m_axis_data1), int'(vecs[i].e_d1));
      check($sformatf("vec%0d_valid2", i), int'(if0.m_axis_valid2), int'(vecs[i].e_v2));
      check($sformatf("vec%0d_data2", i), int'(if0.m_axis_data2), int'(vecs[i].e_d2));
      check($sformatf("vec%0d_count", i), int'(cnt0), vecs[i].e_cnt);
    end

    // back-to-back stream with both consumers always ready
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if0.s_axis_data   = 16'(i);
      if0.s_axis_valid  = 1'b1;
      if0.m_axis_ready1 = 1'b1;
      if0.m_axis_ready2 = 1'b1;
      #1;
      check($sformatf("b2b%0d_ready", i), int'(if0.s_axis_ready), 1);
      if (i > 1) begin
        check($sformatf("b2b%0d_valid1", i), int'(if0.m_axis_valid1), 1);
        check($sformatf("b2b%0d_data1", i), int'(if0.m_axis_data1), i - 1);
        check($sformatf("b2b%0d_valid2", i), int'(if0.m_axis_valid2), 1);
        check($sformatf("b2b%0d_data2", i), int'(if0.m_axis_data2), 0);
      end
    end
    @(negedge clk);
    if0.s_axis_valid = 1'b0;
    #1;
    check("b2b_last_valid1", int'(if0.m_axis_valid1), 1);
    check("b2b_last_data1", int'(if0.m_axis_data1), 16);
    @(negedge clk);
    #1;
    check("b2b_idle_valid1", int'(if0.m_axis_valid1), 0);
    check("b2b_count", int'(cnt0), 19);

    // random valid/readies, SWAP=1, scoreboarded
    sent = 0;
    pending = 1'b0;
    cur = 16'h0000;
    for (int cyc = 0; cyc < 20000 && !(sent == 1000 && q1.size() == 0 && q2.size() == 0); cyc++) begin
      @(negedge clk);
      if1.m_axis_ready1 = 1'($urandom_range(0, 1));
      if1.m_axis_ready2 = 1'($urandom_range(0, 1));
      if (!pending && sent < 1000 && $urandom_range(0, 3) != 0) begin
        cur = 16'($urandom);
        pending = 1'b1;
      end
      if1.s_axis_valid = pending;
      if1.s_axis_data  = cur;
      #1;
      if (if1.m_axis_valid1 && if1.m_axis_ready1) begin
        if (q1.size() == 0) check("sb_lane1_extra", 1, 0);
        else check("sb_lane1", int'(if1.m_axis_data1), int'(q1.pop_front()));
      end
      if (if1.m_axis_valid2 && if1.m_axis_ready2) begin
        if (q2.size() == 0) check("sb_lane2_extra", 1, 0);
        else check("sb_lane2", int'(if1.m_axis_data2), int'(q2.pop_front()));
      end
      if (pending && if1.s_axis_ready) begin
        q1.push_back(cur[15:8]);
        q2.push_back(cur[7:0]);
        sent++;
        pending = 1'b0;
      end
    end
    @(negedge clk);
    if1.s_axis_valid = 1'b0;
    check("sb_sent", sent, 1000);
    check("sb_q1_left", q1.size(), 0);
    check("sb_q2_left", q2.size(), 0);
    check("sb_count", int'(cnt1), 1000);

    // 4-bit counter wrap after 17 words
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if2.s_axis_data  = 16'(16'h0100 + i);
      if2.s_axis_valid = 1'b1;
    end
    @(negedge clk);
    if2.s_axis_valid = 1'b0;
    #1;
    check("wrap_count", int'(cnt2), 1);

    @(negedge clk);
    if2.s_axis_data   = 16'hA55A;
    if2.s_axis_valid  = 1'b1;
    if2.m_axis_ready1 = 1'b0;
    if2.m_axis_ready2 = 1'b0;
    @(negedge clk);
    if2.s_axis_valid = 1'b0;
    #1;
    check("full_valid1", int'(if2.m_axis_valid1), 1);
    check("full_valid2", int'(if2.m_axis_valid2), 1);
    check("full_data1", int'(if2.m_axis_data1), 8'h5A);
    check("full_data2", int'(if2.m_axis_data2), 8'hA5);

    // asynchronous reset between edges with both lanes full
    #2;
    rst2 = 1'b0;
    #1;
    check("arst_valid1", int'(if2.m_axis_valid1), 0);
    check("arst_valid2", int'(if2.m_axis_valid2), 0);
    check("arst_ready", int'(if2.s_axis_ready), 0);
    check("arst_count", int'(cnt2), 0);
    check("arst_data1", int'(if2.m_axis_data1), 0);
    repeat (2) @(negedge clk);
    if2.m_axis_ready1 = 1'b1;
    if2.m_axis_ready2 = 1'b1;
    rst2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("post_rst%0d_valid1", i), int'(if2.m_axis_valid1), 0);
      check($sformatf("post_rst%0d_valid2", i), int'(if2.m_axis_valid2), 0);
      check($sformatf("post_rst%0d_ready", i), int'(if2.s_axis_ready), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
